// File: rtl/mcpu_soc_mmio_pkg.sv
// Shared MMIO bus definitions: master state encoding and region map.
// The responder's decoder imports the same constants.
package mcpu_soc_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int          REGION_LEDSW  = 0;
  localparam int          REGION_UART   = 1;
  localparam int          NUM_REGIONS   = 2;
  localparam int          REGION_SHIFT  = 10;
  localparam int unsigned PARK_ADDR     = 0;

endpackage

// File: rtl/mcpu_soc_mmio_region_decode.sv
// Word address -> region index plus in-range flag. The full upper address
// is compared, so no region aliases into a higher one.
module mcpu_soc_mmio_region_decode #(
  parameter int ADDR_W       = 29,
  parameter int REGION_SHIFT = 10,
  parameter int NUM_REGIONS  = 2
) (
  input  logic [ADDR_W-1:0]              addr,
  output logic [ADDR_W-REGION_SHIFT-1:0] region,
  output logic                           in_range
);

  localparam int RW = ADDR_W - REGION_SHIFT;

  assign region   = addr[ADDR_W-1:REGION_SHIFT];
  assign in_range = (region < RW'(NUM_REGIONS));

endmodule

// File: rtl/mcpu_soc_mmio_master.sv
// MMIO initiator: one registered bus cycle per in-range access, local
// error response for out-of-range addresses, valid/ready on both sides.
module mcpu_soc_mmio_master
  import mcpu_soc_mmio_pkg::*;
#(
  parameter int              ADDR_W       = 29,
  parameter int              DATA_W       = 32,
  parameter int              REGION_SHIFT = mcpu_soc_mmio_pkg::REGION_SHIFT,
  parameter int              NUM_REGIONS  = mcpu_soc_mmio_pkg::NUM_REGIONS,
  parameter logic [ADDR_W-1:0] PARK_ADDR  = ADDR_W'(mcpu_soc_mmio_pkg::PARK_ADDR)
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wen,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mmio_addr,
  output logic [DATA_W/8-1:0] mmio_wren,
  output logic [DATA_W-1:0]   mmio_wdata,
  input  logic [DATA_W-1:0]   mmio_rdata
);

  state_e                        state;
  logic                          in_range;
  logic [ADDR_W-REGION_SHIFT-1:0] region_unused;

  mcpu_soc_mmio_region_decode #(
    .ADDR_W      (ADDR_W),
    .REGION_SHIFT(REGION_SHIFT),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_decode (
    .addr    (req_addr),
    .region  (region_unused),
    .in_range(in_range)
  );

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mmio_addr  <= PARK_ADDR;
      mmio_wren  <= '0;
      mmio_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (in_range) begin
              mmio_addr  <= req_addr;
              mmio_wren  <= req_wen;
              mmio_wdata <= req_wdata;
              state      <= ACCESS;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          // mmio_wren still holds the request's enables: zero means a read
          rsp_rdata  <= (mmio_wren == '0) ? mmio_rdata : '0;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          mmio_addr  <= PARK_ADDR;
          mmio_wren  <= '0;
          mmio_wdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
